// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. It accepts one instruction at a time from the
// execute stage and issues any aligned load or store to data memory. It then
// hands a registered payload to the register-writeback stage. A misaligned or
// timed-out access raises a one-cycle ma_err and suppresses the writeback.
module mem_access_stage #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_aluResult,
    input  logic [31:0] ex_op2,
    input  logic        ex_isLd,
    input  logic        ex_isSt,
    input  logic        ex_isWb,
    input  logic [3:0]  ex_rd,
    input  logic [31:0] ex_pc,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        rw_valid,
    input  logic        rw_ready,
    output logic [31:0] rw_aluResult,
    output logic [31:0] rw_ldResult,
    output logic        rw_isLd,
    output logic        rw_isWb,
    output logic [3:0]  rw_rd,
    output logic [31:0] rw_pc,
    output logic        ma_err
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;

    // Instruction held for the duration of a memory access
    logic [31:0] addr_p0, op2_p0, pc_p0;
    logic        isld_p0, isst_p0, iswb_p0;
    logic [3:0]  rd_p0;

    logic accept, is_mem, misalign;
    logic capture, ld_from_ex, ld_from_cap, err_d;

    assign ex_ready = (state == IDLE) && (!rw_valid || rw_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_isLd || ex_isSt;
    assign misalign = (ex_aluResult[1:0] != 2'b00);

    // The request is gated to zero outside ACCESS so IDLE never leaks stale data
    assign dm_req   = (state == ACCESS);
    assign dm_we    = (state == ACCESS) && isst_p0 && !isld_p0;
    assign dm_addr  = (state == ACCESS) ? addr_p0 : 32'd0;
    assign dm_wdata = (state == ACCESS) ? op2_p0  : 32'd0;

    // Next-state, timeout counter and payload-load decisions
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        capture     = 1'b0;
        ld_from_ex  = 1'b0;
        ld_from_cap = 1'b0;
        err_d       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_mem) begin
                        ld_from_ex = 1'b1;
                    end else if (misalign) begin
                        ld_from_ex = 1'b1;
                        err_d      = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = ACCESS;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still completes normally
                if (dm_ack) begin
                    ld_from_cap = 1'b1;
                    state_d     = IDLE;
                end else if (cnt == TO_LAST) begin
                    ld_from_cap = 1'b1;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Capture the accepted memory instruction; held untouched while in ACCESS
    always_ff @(posedge clk) begin
        if (capture) begin
            addr_p0 <= ex_aluResult;
            op2_p0  <= ex_op2;
            isld_p0 <= ex_isLd;
            isst_p0 <= ex_isSt;
            iswb_p0 <= ex_isWb;
            rd_p0   <= ex_rd;
            pc_p0   <= ex_pc;
        end
    end

    // ---- stage boundary: writeback payload register ----
    // Load a new payload or hold it; an error always cancels register writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_valid     <= 1'b0;
            rw_aluResult <= 32'd0;
            rw_ldResult  <= 32'd0;
            rw_isLd      <= 1'b0;
            rw_isWb      <= 1'b0;
            rw_rd        <= 4'd0;
            rw_pc        <= 32'd0;
            ma_err       <= 1'b0;
        end else begin
            ma_err <= err_d;
            if (ld_from_ex) begin
                rw_valid     <= 1'b1;
                rw_aluResult <= ex_aluResult;
                rw_ldResult  <= 32'd0;
                rw_isLd      <= ex_isLd;
                rw_isWb      <= ex_isWb && !err_d;
                rw_rd        <= ex_rd;
                rw_pc        <= ex_pc;
            end else if (ld_from_cap) begin
                rw_valid     <= 1'b1;
                rw_aluResult <= addr_p0;
                rw_ldResult  <= (isld_p0 && !err_d) ? dm_rdata : 32'd0;
                rw_isLd      <= isld_p0;
                rw_isWb      <= iswb_p0 && !err_d;
                rw_rd        <= rd_p0;
                rw_pc        <= pc_p0;
            end else if (rw_ready) begin
                rw_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short timeout of 4 ACCESS cycles.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_aluResult, ex_op2, ex_pc;
    logic        ex_isLd, ex_isSt, ex_isWb;
    logic [3:0]  ex_rd;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        rw_valid, rw_ready;
    logic [31:0] rw_aluResult, rw_ldResult, rw_pc;
    logic        rw_isLd, rw_isWb, ma_err;
    logic [3:0]  rw_rd;

    int checks = 0;
    int failures = 0;

    mem_access_stage #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluResult(ex_aluResult), .ex_op2(ex_op2),
        .ex_isLd(ex_isLd), .ex_isSt(ex_isSt), .ex_isWb(ex_isWb),
        .ex_rd(ex_rd), .ex_pc(ex_pc),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .rw_valid(rw_valid), .rw_ready(rw_ready),
        .rw_aluResult(rw_aluResult), .rw_ldResult(rw_ldResult),
        .rw_isLd(rw_isLd), .rw_isWb(rw_isWb), .rw_rd(rw_rd), .rw_pc(rw_pc),
        .ma_err(ma_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] op2,
                         input logic ld, input logic st, input logic wb,
                         input logic [3:0] rd, input logic [31:0] pc);
        ex_valid = v; ex_aluResult = alu; ex_op2 = op2;
        ex_isLd = ld; ex_isSt = st; ex_isWb = wb; ex_rd = rd; ex_pc = pc;
    endtask

    typedef struct {
        logic [31:0] alu, op2, pc;
        logic        ld, st, wb;
        logic [3:0]  rd;
        logic [31:0] e_ld;
        logic        e_wb, e_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{alu:32'd5,        op2:32'd0,  pc:32'h10,       ld:1'b0, st:1'b0, wb:1'b1, rd:4'd3,  e_ld:32'd0, e_wb:1'b1, e_err:1'b0};
        vecs[1] = '{alu:32'd7,        op2:32'd0,  pc:32'h14,       ld:1'b0, st:1'b0, wb:1'b1, rd:4'd4,  e_ld:32'd0, e_wb:1'b1, e_err:1'b0};
        vecs[2] = '{alu:32'h102,      op2:32'h55, pc:32'h18,       ld:1'b0, st:1'b1, wb:1'b1, rd:4'd1,  e_ld:32'd0, e_wb:1'b0, e_err:1'b1};
        vecs[3] = '{alu:32'h203,      op2:32'd0,  pc:32'h1C,       ld:1'b1, st:1'b0, wb:1'b1, rd:4'd5,  e_ld:32'd0, e_wb:1'b0, e_err:1'b1};
        vecs[4] = '{alu:32'hFFFFFFFF, op2:32'd9,  pc:32'h80000000, ld:1'b0, st:1'b0, wb:1'b0, rd:4'd15, e_ld:32'd0, e_wb:1'b0, e_err:1'b0};

        rst = 1'b1; rw_ready = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        step(); step();
        rst = 1'b0;
        chk("rst_rw_valid", {31'd0, rw_valid}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_ma_err", {31'd0, ma_err}, 32'd0);
        chk("rst_rw_alu", rw_aluResult, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        // Non-memory and misaligned ops, one accepted per cycle
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].alu, vecs[i].op2, vecs[i].ld, vecs[i].st, vecs[i].wb, vecs[i].rd, vecs[i].pc);
            #1;
            chk($sformatf("v%0d_ex_ready", i), {31'd0, ex_ready}, 32'd1);
            step();
            chk($sformatf("v%0d_rw_valid", i), {31'd0, rw_valid}, 32'd1);
            chk($sformatf("v%0d_rw_alu", i), rw_aluResult, vecs[i].alu);
            chk($sformatf("v%0d_rw_ld", i), rw_ldResult, vecs[i].e_ld);
            chk($sformatf("v%0d_rw_isLd", i), {31'd0, rw_isLd}, {31'd0, vecs[i].ld});
            chk($sformatf("v%0d_rw_isWb", i), {31'd0, rw_isWb}, {31'd0, vecs[i].e_wb});
            chk($sformatf("v%0d_rw_rd", i), {28'd0, rw_rd}, {28'd0, vecs[i].rd});
            chk($sformatf("v%0d_rw_pc", i), rw_pc, vecs[i].pc);
            chk($sformatf("v%0d_ma_err", i), {31'd0, ma_err}, {31'd0, vecs[i].e_err});
            chk($sformatf("v%0d_dm_req", i), {31'd0, dm_req}, 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        step();
        chk("drain_rw_valid", {31'd0, rw_valid}, 32'd0);
        chk("drain_ma_err", {31'd0, ma_err}, 32'd0);

        // Load at 0x100, ack in the third ACCESS cycle
        drive(1'b1, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 4'd6, 32'h200);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk("ld_c1_req", {31'd0, dm_req}, 32'd1);
        chk("ld_c1_addr", dm_addr, 32'h100);
        chk("ld_c1_we", {31'd0, dm_we}, 32'd0);
        chk("ld_c1_ex_ready", {31'd0, ex_ready}, 32'd0);
        step();
        chk("ld_c2_req", {31'd0, dm_req}, 32'd1);
        chk("ld_c2_ex_ready", {31'd0, ex_ready}, 32'd0);
        step();
        chk("ld_c3_req", {31'd0, dm_req}, 32'd1);
        chk("ld_c3_addr", dm_addr, 32'h100);
        dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
        step();
        dm_ack = 1'b0;
        chk("ld_done_req", {31'd0, dm_req}, 32'd0);
        chk("ld_done_valid", {31'd0, rw_valid}, 32'd1);
        chk("ld_done_ldres", rw_ldResult, 32'hDEADBEEF);
        chk("ld_done_isWb", {31'd0, rw_isWb}, 32'd1);
        chk("ld_done_rd", {28'd0, rw_rd}, 32'd6);
        chk("ld_done_pc", rw_pc, 32'h200);
        chk("ld_done_err", {31'd0, ma_err}, 32'd0);
        // An ack while idle must not produce anything
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        chk("idle_ack_valid", {31'd0, rw_valid}, 32'd0);

        // Aligned store, ack in the first ACCESS cycle
        drive(1'b1, 32'h40, 32'h12345678, 1'b0, 1'b1, 1'b0, 4'd2, 32'h300);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk("st_we", {31'd0, dm_we}, 32'd1);
        chk("st_wdata", dm_wdata, 32'h12345678);
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        step();
        dm_ack = 1'b0;
        chk("st_valid", {31'd0, rw_valid}, 32'd1);
        chk("st_ldres", rw_ldResult, 32'd0);
        chk("st_alu", rw_aluResult, 32'h40);

        // Load and store both set behaves as a load
        drive(1'b1, 32'h44, 32'hAAAA5555, 1'b1, 1'b1, 1'b1, 4'd7, 32'h304);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk("ldst_req", {31'd0, dm_req}, 32'd1);
        chk("ldst_we", {31'd0, dm_we}, 32'd0);
        dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
        step();
        dm_ack = 1'b0;
        chk("ldst_ldres", rw_ldResult, 32'h0BADF00D);
        step();

        // Timeout: no ack for 4 ACCESS cycles
        drive(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 4'd8, 32'h400);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_c%0d_req", c), {31'd0, dm_req}, 32'd1);
            chk($sformatf("to_c%0d_err", c), {31'd0, ma_err}, 32'd0);
            step();
        end
        chk("to_req_drop", {31'd0, dm_req}, 32'd0);
        chk("to_err", {31'd0, ma_err}, 32'd1);
        chk("to_valid", {31'd0, rw_valid}, 32'd1);
        chk("to_ldres", rw_ldResult, 32'd0);
        chk("to_isWb", {31'd0, rw_isWb}, 32'd0);
        chk("to_pc", rw_pc, 32'h400);
        step();
        chk("to_err_pulse", {31'd0, ma_err}, 32'd0);

        // Ack on the final allowed cycle wins over timeout
        drive(1'b1, 32'h304, 32'h0, 1'b1, 1'b0, 1'b1, 4'd9, 32'h404);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        step(); step(); step();
        chk("prec_c4_req", {31'd0, dm_req}, 32'd1);
        dm_ack = 1'b1; dm_rdata = 32'h13579BDF;
        step();
        dm_ack = 1'b0;
        chk("prec_err", {31'd0, ma_err}, 32'd0);
        chk("prec_isWb", {31'd0, rw_isWb}, 32'd1);
        chk("prec_ldres", rw_ldResult, 32'h13579BDF);
        step();

        // Backpressure: payload held 5 cycles, then drained with a same-edge accept
        rw_ready = 1'b0;
        drive(1'b1, 32'hAA, 32'h0, 1'b0, 1'b0, 1'b1, 4'd10, 32'h500);
        step();
        drive(1'b1, 32'hBB, 32'h0, 1'b0, 1'b0, 1'b1, 4'd11, 32'h504);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), {31'd0, rw_valid}, 32'd1);
            chk($sformatf("bp%0d_alu", c), rw_aluResult, 32'hAA);
            chk($sformatf("bp%0d_rd", c), {28'd0, rw_rd}, 32'd10);
            chk($sformatf("bp%0d_ex_ready", c), {31'd0, ex_ready}, 32'd0);
            step();
        end
        rw_ready = 1'b1;
        #1;
        chk("bp_release_ex_ready", {31'd0, ex_ready}, 32'd1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk("bp_next_valid", {31'd0, rw_valid}, 32'd1);
        chk("bp_next_alu", rw_aluResult, 32'hBB);
        chk("bp_next_pc", rw_pc, 32'h504);
        step();
        chk("bp_empty", {31'd0, rw_valid}, 32'd0);

        // Reset in the second ACCESS cycle discards the access
        drive(1'b1, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1, 4'd12, 32'h600);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
        chk("rs_c1_req", {31'd0, dm_req}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_req", {31'd0, dm_req}, 32'd0);
        chk("rs_valid", {31'd0, rw_valid}, 32'd0);
        chk("rs_err", {31'd0, ma_err}, 32'd0);
        chk("rs_ex_ready", {31'd0, ex_ready}, 32'd1);
        dm_ack = 1'b1; dm_rdata = 32'h11111111;
        step();
        dm_ack = 1'b0;
        chk("rs_late_ack_valid", {31'd0, rw_valid}, 32'd0);
        chk("rs_late_ack_req", {31'd0, dm_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the number of ACCESS cycles without dm_ack before the access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ex_valid, input, 1 bit: the execution stage presents an instruction.
REQ-005 SHALL have port ex_ready, output, 1 bit: the stage accepts the instruction this cycle.
REQ-006 SHALL have port ex_aluResult, input, 32 bits: ALU result, also the memory address.
REQ-007 SHALL have port ex_op2, input, 32 bits: store data.
REQ-008 SHALL have ports ex_isLd, ex_isSt and ex_isWb, input, 1 bit each: load, store and register-writeback flags.
REQ-009 SHALL have port ex_rd, input, 4 bits: destination register index.
REQ-010 SHALL have port ex_pc, input, 32 bits: instruction PC.
REQ-011 SHALL have ports dm_req (output, 1 bit), dm_we (output, 1 bit), dm_addr (output, 32 bits) and dm_wdata (output, 32 bits): the data-memory request.
REQ-012 SHALL have ports dm_ack (input, 1 bit) and dm_rdata (input, 32 bits): memory completion and load data.
REQ-013 SHALL have ports rw_valid (output, 1 bit) and rw_ready (input, 1 bit): the handshake to the register-writeback stage.
REQ-014 SHALL have ports rw_aluResult (output, 32 bits), rw_ldResult (output, 32 bits), rw_isLd (output, 1 bit), rw_isWb (output, 1 bit), rw_rd (output, 4 bits) and rw_pc (output, 32 bits): the registered writeback payload.
REQ-015 SHALL have port ma_err, output, 1 bit: one-cycle pulse on a misaligned or timed-out access.

Function
REQ-016 SHALL implement FSM states IDLE and ACCESS.
REQ-017 SHALL drive ex_ready = (state==IDLE) && (!rw_valid || rw_ready), combinationally.
REQ-018 SHALL treat an instruction as accepted when ex_valid && ex_ready; all ex_* fields are captured on that edge.
REQ-019 SHALL, for an accepted non-memory op (ex_isLd==0 and ex_isSt==0), load the rw_* payload on the accept edge, giving rw_valid=1 the next cycle (latency 1), with rw_ldResult=0; state stays IDLE.
REQ-020 SHALL, for an accepted op with ex_isLd and ex_isSt both set, treat it as a load and issue no write.
REQ-021 SHALL, for an accepted memory op with ex_aluResult[1:0]!=0, issue no dm_req, pulse ma_err for 1 cycle, and load the payload with rw_isWb=0 and rw_ldResult=0 (latency 1).
REQ-022 SHALL, for an accepted aligned memory op, enter ACCESS and hold the memory request while in ACCESS:
- dm_req=1;
- dm_addr = captured address;
- dm_we = store and not load;
- dm_wdata = captured op2.
All four SHALL stay stable until the access completes.
REQ-023 SHALL drive dm_req=0, dm_we=0, dm_addr=0 and dm_wdata=0 in IDLE.
REQ-024 SHALL complete the access in ACCESS when dm_ack=1:
- load the payload, with rw_ldResult = dm_rdata for loads and 0 for stores;
- set rw_valid=1 the next cycle;
- return to IDLE.
Minimum memory-op latency is 2 cycles (accept edge, then ack in the first ACCESS cycle).
REQ-025 SHALL count ACCESS cycles, resetting the count on entry to ACCESS.
REQ-026 SHALL abort when the count reaches TIMEOUT_CYC with no dm_ack:
- return to IDLE, dropping dm_req;
- pulse ma_err;
- emit the payload with rw_isWb=0 and rw_ldResult=0.
REQ-027 SHALL give dm_ack precedence over timeout when both occur in the same cycle.
REQ-028 SHALL ignore dm_ack while in IDLE.
REQ-029 SHALL hold all rw_* fields stable while rw_valid && !rw_ready.
REQ-030 SHALL clear rw_valid on rw_ready unless a new payload loads on the same edge.
REQ-031 SHALL, when a payload is consumed and a non-memory op is accepted on the same edge, keep rw_valid=1 with the new payload (full throughput of 1 op per cycle).
REQ-032 SHALL pass ex_aluResult, ex_isLd, ex_rd and ex_pc through unchanged to rw_aluResult, rw_isLd, rw_rd and rw_pc.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, set state=IDLE, clear the counter, and drive every output to 0 (except combinational ex_ready, which follows REQ-017) from the next cycle.
REQ-034 SHALL, on rst asserted during ACCESS, drop dm_req the next cycle and discard the in-flight access without a writeback or ma_err.
REQ-035 SHALL take rst priority over every other event in the same cycle.

Verification
REQ-036 SHALL cover back-to-back ADD ops with rw_ready=1 held: ex_aluResult=5, then 7 -> rw_aluResult=5, then 7 on consecutive cycles; ex_ready stays 1.
REQ-037 SHALL cover a load at 0x100 with dm_ack after 3 ACCESS cycles and dm_rdata=0xDEADBEEF -> dm_req high for 3 cycles, ex_ready=0 meanwhile, then rw_ldResult=0xDEADBEEF with rw_valid=1.
REQ-038 SHALL cover a store at 0x102 -> no dm_req, ma_err=1 for exactly 1 cycle, rw_isWb=0.
REQ-039 SHALL cover a load with dm_ack never asserted and TIMEOUT_CYC=4 -> dm_req high for 4 cycles, then ma_err pulse, rw_ldResult=0, rw_isWb=0.
REQ-040 SHALL cover an op with rw_ready=0 held for 5 cycles after rw_valid -> payload stable and ex_ready=0 throughout; rw_ready=1 drains it.
REQ-041 SHALL cover rst asserted in the second ACCESS cycle -> dm_req=0 and rw_valid=0 the next cycle, and a late dm_ack is ignored.
